// File: rtl/ph_pkg.sv
// Shared constants and helpers for the parasite-to-host Tube register quad.
package ph_pkg;
  localparam int NUM_REGS = 4;
  localparam int R1 = 0;
  localparam int R2 = 1;
  localparam int R3 = 2;
  localparam int R4 = 3;
  localparam int R1_DEPTH = 24;
  localparam int DW = 8;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction
endpackage

// File: rtl/ph_fifo.sv
// Small FIFO with a runtime capacity limit; head byte is combinational, flags follow the count register.
// Caller gates wr/rd: wr is never asserted when full unless rd is also accepted, rd never when empty.
module ph_fifo #(
  parameter int DEPTH = 2,
  parameter int DW = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] cap,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          avail
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= nxt(wp);
      end
      if (rd) rp <= nxt(rp);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stale storage is visible on an empty read, so no empty gating here.
  assign dout  = mem[rp];
  assign full  = (count >= cap);
  assign avail = (count != '0);
endmodule

// File: rtl/ph_fifo_quad.sv
// Parasite-to-host quad: four buffered registers, one write and one read per register per cycle.
// Writes to a full register are dropped unless a read of it is accepted the same cycle; empty reads are ignored.
module ph_fifo_quad import ph_pkg::*; #(
  parameter int R1_DEPTH = ph_pkg::R1_DEPTH,
  parameter int DW = ph_pkg::DW
) (
  input  logic                p_phi2,
  input  logic                p_rst,
  input  logic                p_we,
  input  logic [NUM_REGS-1:0] p_selectData,
  input  logic [DW-1:0]       p_data,
  input  logic                h_rd,
  input  logic [NUM_REGS-1:0] h_selectData,
  input  logic                one_byte_mode,
  output logic [DW-1:0]       h_data,
  output logic [NUM_REGS-1:0] h_data_available,
  output logic                h_r3_one_byte_available,
  output logic [NUM_REGS-1:0] p_full
);
  localparam int R1_CW = $clog2(R1_DEPTH + 1);

  logic [DW-1:0]       dout [NUM_REGS];
  logic [NUM_REGS-1:0] wr_acc, rd_acc, full_c, avail_c, has_data;
  logic [R1_CW-1:0]    cnt1;
  logic                cnt2, cnt4;
  logic [1:0]          cnt3;
  logic                wr_ok, rd_ok;

  assign wr_ok    = p_we & is_onehot4(p_selectData);
  assign rd_ok    = h_rd & is_onehot4(h_selectData);
  assign has_data = {cnt4, |cnt3, cnt2, |cnt1};
  assign rd_acc   = {NUM_REGS{rd_ok}} & h_selectData & has_data;
  // A same-cycle read frees the slot, so a full register still accepts the write.
  assign wr_acc   = {NUM_REGS{wr_ok}} & p_selectData & (~full_c | rd_acc);

  ph_fifo #(.DEPTH(R1_DEPTH), .DW(DW)) u_r1 (
    .clk(p_phi2), .rst(p_rst), .wr(wr_acc[R1]), .rd(rd_acc[R1]), .din(p_data),
    .cap(R1_CW'(R1_DEPTH)), .dout(dout[R1]), .count(cnt1), .full(full_c[R1]), .avail(avail_c[R1])
  );

  ph_fifo #(.DEPTH(1), .DW(DW)) u_r2 (
    .clk(p_phi2), .rst(p_rst), .wr(wr_acc[R2]), .rd(rd_acc[R2]), .din(p_data),
    .cap(1'b1), .dout(dout[R2]), .count(cnt2), .full(full_c[R2]), .avail(avail_c[R2])
  );

  ph_fifo #(.DEPTH(2), .DW(DW)) u_r3 (
    .clk(p_phi2), .rst(p_rst), .wr(wr_acc[R3]), .rd(rd_acc[R3]), .din(p_data),
    .cap(one_byte_mode ? 2'd1 : 2'd2), .dout(dout[R3]), .count(cnt3), .full(full_c[R3]),
    .avail(avail_c[R3])
  );

  ph_fifo #(.DEPTH(1), .DW(DW)) u_r4 (
    .clk(p_phi2), .rst(p_rst), .wr(wr_acc[R4]), .rd(rd_acc[R4]), .din(p_data),
    .cap(1'b1), .dout(dout[R4]), .count(cnt4), .full(full_c[R4]), .avail(avail_c[R4])
  );

  // R3 reports available only at capacity, so two-byte mode exposes whole pairs.
  assign h_data_available        = {avail_c[R4], full_c[R3], avail_c[R2], avail_c[R1]};
  assign h_r3_one_byte_available = avail_c[R3];
  assign p_full                  = full_c;

  always_comb begin
    h_data = '0;
    case (h_selectData)
      4'b0001: h_data = dout[R1];
      4'b0010: h_data = dout[R2];
      4'b0100: h_data = dout[R3];
      4'b1000: h_data = dout[R4];
      default: h_data = '0;
    endcase
  end
endmodule

// File: tb/tb_ph_fifo_quad.sv
// Directed bench for ph_fifo_quad with per-register scoreboard queues and a count model.
module tb_ph_fifo_quad;
  logic       p_phi2 = 1'b0;
  logic       p_rst, p_we, h_rd, one_byte_mode;
  logic [3:0] p_selectData, h_selectData;
  logic [7:0] p_data;
  logic [7:0] h_data;
  logic [3:0] h_data_available, p_full;
  logic       h_r3_one_byte_available;

  int checks = 0;
  int errors = 0;
  int cnt [4];
  logic [7:0] sbq [4][$];

  ph_fifo_quad dut (
    .p_phi2(p_phi2), .p_rst(p_rst), .p_we(p_we), .p_selectData(p_selectData),
    .p_data(p_data), .h_rd(h_rd), .h_selectData(h_selectData),
    .one_byte_mode(one_byte_mode), .h_data(h_data), .h_data_available(h_data_available),
    .h_r3_one_byte_available(h_r3_one_byte_available), .p_full(p_full)
  );

  always #5 p_phi2 = ~p_phi2;

  function automatic int sel_idx(input logic [3:0] s);
    int r = -1;
    if (s != 4'b0000 && (s & (s - 4'd1)) == 4'b0000)
      for (int i = 0; i < 4; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic int cap_of(input int i);
    if (i == 0) return 24;
    if (i == 2) return one_byte_mode ? 1 : 2;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    logic [3:0] ea, ef;
    for (int i = 0; i < 4; i++) begin
      ef[i] = (cnt[i] >= cap_of(i));
      ea[i] = (i == 2) ? ef[i] : (cnt[i] >= 1);
    end
    check({tag, "_avail"}, {28'd0, h_data_available}, {28'd0, ea});
    check({tag, "_full"}, {28'd0, p_full}, {28'd0, ef});
    check({tag, "_r3one"}, {31'd0, h_r3_one_byte_available}, {31'd0, cnt[2] >= 1});
  endtask

  task automatic show(input logic [3:0] rsel);
    h_selectData = rsel;
    #1;
  endtask

  // One clock of stimulus; the model decides acceptance and checks read data against the scoreboard.
  task automatic step(input logic we, input logic [3:0] wsel, input logic [7:0] wd,
                      input logic rd, input logic [3:0] rsel);
    int wi, ri;
    logic racc, wacc;
    p_we = we; p_selectData = wsel; p_data = wd; h_rd = rd; h_selectData = rsel;
    #1;
    wi = sel_idx(wsel);
    ri = sel_idx(rsel);
    racc = rd && (ri >= 0) && (cnt[ri] >= 1);
    wacc = we && (wi >= 0) && ((cnt[wi] < cap_of(wi)) || (racc && ri == wi));
    if (racc) begin
      check("rd_data", {24'd0, h_data}, {24'd0, sbq[ri][0]});
      void'(sbq[ri].pop_front());
      cnt[ri]--;
    end
    if (wacc) begin
      sbq[wi].push_back(wd);
      cnt[wi]++;
    end
    @(posedge p_phi2);
    #1;
    p_we = 1'b0; h_rd = 1'b0;
  endtask

  task automatic do_reset(input logic we_during);
    p_rst = 1'b1; p_we = we_during; p_selectData = 4'b0001; p_data = 8'hEE;
    @(posedge p_phi2);
    #1;
    p_rst = 1'b0; p_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      sbq[i].delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_flags(tag);
    check({tag, "_availz"}, {28'd0, h_data_available}, 32'd0);
    check({tag, "_fullz"}, {28'd0, p_full}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      show(4'b0001 << i);
      check({tag, "_hdata"}, {24'd0, h_data}, 32'd0);
    end
  endtask

  initial begin
    p_rst = 1'b0; p_we = 1'b0; h_rd = 1'b0; one_byte_mode = 1'b0;
    p_selectData = 4'b0000; h_selectData = 4'b0000; p_data = 8'h00;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    @(posedge p_phi2);
    #1;
    do_reset(1'b1);
    check_zero_outputs("reset");

    // R1 fill, overflow drop, then read+write at full
    for (int i = 0; i < 24; i++) step(1'b1, 4'b0001, 8'(i), 1'b0, 4'b0001);
    check("r1_full", {31'd0, p_full[0]}, 32'd1);
    check_flags("r1_filled");
    step(1'b1, 4'b0001, 8'hFF, 1'b0, 4'b0001);
    check_flags("r1_overflow");
    show(4'b0001);
    check("r1_head", {24'd0, h_data}, 32'h00);
    step(1'b1, 4'b0001, 8'hAA, 1'b1, 4'b0001);
    check("r1_rw_head", {24'd0, h_data}, 32'h01);
    check("r1_rw_full", {31'd0, p_full[0]}, 32'd1);
    for (int i = 0; i < 23; i++) step(1'b0, 4'b0000, 8'h00, 1'b1, 4'b0001);
    check("r1_last", {24'd0, h_data}, 32'hAA);
    step(1'b0, 4'b0000, 8'h00, 1'b1, 4'b0001);
    check("r1_drained", {31'd0, h_data_available[0]}, 32'd0);
    check_flags("r1_empty");

    // R3 two-byte mode
    one_byte_mode = 1'b0;
    step(1'b1, 4'b0100, 8'h11, 1'b0, 4'b0100);
    check("r3_one_avail", {31'd0, h_r3_one_byte_available}, 32'd1);
    check("r3_not_avail", {31'd0, h_data_available[2]}, 32'd0);
    step(1'b1, 4'b0100, 8'h22, 1'b0, 4'b0100);
    check("r3_pair_avail", {31'd0, h_data_available[2]}, 32'd1);
    check("r3_pair_full", {31'd0, p_full[2]}, 32'd1);
    step(1'b0, 4'b0000, 8'h00, 1'b1, 4'b0100);
    step(1'b0, 4'b0000, 8'h00, 1'b1, 4'b0100);
    check_flags("r3_two_drained");

    // R3 one-byte mode
    one_byte_mode = 1'b1;
    step(1'b1, 4'b0100, 8'h33, 1'b0, 4'b0100);
    check("r3_1b_full", {31'd0, p_full[2]}, 32'd1);
    step(1'b1, 4'b0100, 8'h44, 1'b0, 4'b0100);
    check_flags("r3_1b_drop");
    check("r3_1b_head", {24'd0, h_data}, 32'h33);
    step(1'b0, 4'b0000, 8'h00, 1'b1, 4'b0100);
    check_flags("r3_1b_drained");

    // R2 simultaneous op on empty, invalid selects
    step(1'b1, 4'b0010, 8'h55, 1'b1, 4'b0010);
    check("r2_bypass_none", {24'd0, h_data}, 32'h55);
    check("r2_avail", {31'd0, h_data_available[1]}, 32'd1);
    check_flags("r2_one");
    step(1'b1, 4'b0011, 8'h99, 1'b1, 4'b0110);
    check("r2_bad_sel_hdata", {24'd0, h_data}, 32'h00);
    check_flags("r2_bad_sel");
    show(4'b0010);
    check("r2_unchanged", {24'd0, h_data}, 32'h55);
    step(1'b0, 4'b0000, 8'h00, 1'b1, 4'b0010);
    check_flags("r2_drained");

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 8'h60 + 8'(i), 1'b0, 4'b0001);
    step(1'b1, 4'b1000, 8'h77, 1'b0, 4'b1000);
    check("r4_full", {31'd0, p_full[3]}, 32'd1);
    check_flags("pre_reset");
    do_reset(1'b1);
    check_zero_outputs("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
